wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A = ALU/R-type result, B = memory-load result.
- Drives the 1-bit select of the downstream 5-bit destination mux and the 32-bit writeback data mux.
- Presents one registered write per cycle to the register file.
- Sits between the EX/MEM result paths and the register file in the MIPS datapath.

---
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// ALU result (A) and the memory-load result (B). Grants are combinational
// (one per cycle, round-robin on contention); the register-file write is
// registered with one cycle of latency.
// Optional feature macro: WB_PORT_ARBITER_COLLIDE_CNT_EN adds a saturating
// 16-bit contention counter on port collide_cnt.
module wb_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit B_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_dst,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dst,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rf_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              mux_sel
`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
    ,
    output logic [15:0]       collide_cnt
`endif
);

    // Round-robin pointer states: which side wins the next contention.
    localparam logic PREF_A = 1'b0;
    localparam logic PREF_B = 1'b1;

    logic              rr_ptr_q,  rr_ptr_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              mux_sel_q, mux_sel_d;

    logic              contend;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_dst;
    logic [DATA_W-1:0] sel_data;

    // Grant decision: nothing while busy or in reset, otherwise the lone
    // requester or, on contention, the side named by the pointer.
    always_comb begin
        contend = a_valid & b_valid & ~rf_busy;
        grant_a = rst_n & ~rf_busy & a_valid & (~b_valid | (rr_ptr_q == PREF_A));
        grant_b = rst_n & ~rf_busy & b_valid & (~a_valid | (rr_ptr_q == PREF_B));
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Next-state for the write registers and pointer; a $0 write is accepted
    // and moves the mux select but never raises the write enable.
    always_comb begin
        sel_dst   = grant_b ? b_dst  : a_dst;
        sel_data  = grant_b ? b_data : a_data;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mux_sel_d = mux_sel_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_a || grant_b) begin
            wr_en_d   = (sel_dst != '0);
            wr_addr_d = sel_dst;
            wr_data_d = sel_data;
            mux_sel_d = grant_b;
        end
        if (contend) begin
            rr_ptr_d = grant_b ? PREF_A : PREF_B;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= B_FIRST;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mux_sel_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mux_sel_q <= mux_sel_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign mux_sel = mux_sel_q;

`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
    logic [15:0] collide_cnt_q, collide_cnt_d;

    // Saturating count of contended cycles.
    always_comb begin
        collide_cnt_d = collide_cnt_q;
        if (contend && (collide_cnt_q != 16'hFFFF)) begin
            collide_cnt_d = collide_cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collide_cnt_q <= 16'd0;
        end else begin
            collide_cnt_q <= collide_cnt_d;
        end
    end

    assign collide_cnt = collide_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed steps followed by a randomized
// phase, all checked against a transaction-level model of the arbiter.
// Define WB_PORT_ARBITER_COLLIDE_CNT_EN to also exercise collide_cnt.
module tb_wb_port_arbiter;

    localparam bit B_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, rf_busy;
    logic        a_ready, b_ready;
    logic [4:0]  a_dst, b_dst;
    logic [31:0] a_data, b_data;
    logic        wr_en, mux_sel;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
    logic [15:0] collide_cnt;
`endif

    int total  = 0;
    int passed = 0;

    // Model state: expected register outputs and contention history.
    bit          m_en, m_sel;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_contentions;
    bit          m_last_winner_b;
    bit          last_ga, last_gb;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .B_FIRST(B_FIRST)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
        .rf_busy(rf_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mux_sel(mux_sel)
`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
        , .collide_cnt(collide_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: check grants before the edge, then advance the model
    // and check the registered outputs just after the edge.
    task automatic step(input string tag);
        bit ga, gb, cont, winner_b;
        @(negedge clk);
        cont = rst_n && !rf_busy && a_valid && b_valid;
        winner_b = (m_contentions == 0) ? B_FIRST : !m_last_winner_b;
        ga = 1'b0;
        gb = 1'b0;
        if (rst_n && !rf_busy) begin
            if (cont) begin
                gb = winner_b;
                ga = !winner_b;
            end else begin
                ga = a_valid;
                gb = b_valid;
            end
        end
        check({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ga});
        check({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, gb});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_en = 0; m_sel = 0; m_addr = '0; m_data = '0;
            m_contentions = 0;
        end else if (ga || gb) begin
            m_sel  = gb;
            m_addr = gb ? b_dst : a_dst;
            m_data = gb ? b_data : a_data;
            m_en   = (m_addr != 5'd0);
        end else begin
            m_en = 0;
        end
        if (cont) begin
            m_contentions++;
            m_last_winner_b = gb;
        end
        last_ga = ga;
        last_gb = gb;
        check({tag, ".wr_en"},   {31'd0, wr_en},   {31'd0, m_en});
        check({tag, ".mux_sel"}, {31'd0, mux_sel}, {31'd0, m_sel});
        check({tag, ".wr_addr"}, {27'd0, wr_addr}, {27'd0, m_addr});
        check({tag, ".wr_data"}, wr_data, m_data);
`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
        check({tag, ".collide_cnt"}, {16'd0, collide_cnt},
              (m_contentions > 65535) ? 32'd65535 : m_contentions);
`endif
        $display("%0t %s: a(v%0b r%0b) b(v%0b r%0b) busy=%0b -> wr_en=%0b addr=%0d data=%h sel=%0b",
                 $time, tag, a_valid, ga, b_valid, gb, rf_busy, wr_en, wr_addr, wr_data, mux_sel);
    endtask

    initial begin
        rst_n = 0; rf_busy = 0;
        a_valid = 1; a_dst = 5'd3; a_data = 32'hAAAA0003;
        b_valid = 1; b_dst = 5'd4; b_data = 32'hBBBB0004;
        m_contentions = 0; m_last_winner_b = 0;
        m_en = 0; m_sel = 0; m_addr = '0; m_data = '0;

        // Reset held two cycles with both requesters valid.
        step("rst0");
        step("rst1");

        // Contention: expect B, A, B, A.
        rst_n = 1;
        step("cont0"); check("cont0.grant_b", {31'd0, last_gb}, 32'd1);
        check("cont0.addr", {27'd0, wr_addr}, 32'd4);
        step("cont1"); check("cont1.addr", {27'd0, wr_addr}, 32'd3);
        step("cont2"); check("cont2.addr", {27'd0, wr_addr}, 32'd4);
        step("cont3"); check("cont3.addr", {27'd0, wr_addr}, 32'd3);
        check("cont3.sel", {31'd0, mux_sel}, 32'd0);

        // Single requester A.
        b_valid = 0; a_dst = 5'd9; a_data = 32'hDEADBEEF;
        step("singleA");
        check("singleA.data", wr_data, 32'hDEADBEEF);
        a_valid = 0;
        step("idle");

        // Write to $0 from B: accepted, no enable, select moves to B.
        b_valid = 1; b_dst = 5'd0; b_data = 32'h00001234;
        step("zero");
        check("zero.wr_en", {31'd0, wr_en}, 32'd0);
        check("zero.sel", {31'd0, mux_sel}, 32'd1);
        b_valid = 0;
        step("idle2");

        // Busy stall with both valid, then release.
        a_valid = 1; a_dst = 5'd7; a_data = 32'h70707070;
        b_valid = 1; b_dst = 5'd8; b_data = 32'h80808080;
        rf_busy = 1;
        step("busy0"); step("busy1"); step("busy2");
        rf_busy = 0;
        step("rel0");
        step("rel1");

        // Mid-stream reset discards the write of that cycle.
        rst_n = 0;
        step("midrst");
        rst_n = 1;

        // Randomized traffic; requesters hold dst/data until accepted.
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 300; i++) begin
            if (!a_valid || last_ga) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_dst   = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || last_gb) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_dst   = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            rf_busy = ($urandom_range(0, 4) == 0);
            step("rand");
        end

`ifdef WB_PORT_ARBITER_COLLIDE_CNT_EN
        // Saturation of the contention counter.
        rst_n = 0; step("satrst"); rst_n = 1;
        a_valid = 1; b_valid = 1; rf_busy = 0;
        repeat (65540) @(posedge clk);
        #1;
        check("sat.cnt", {16'd0, collide_cnt}, 32'h0000FFFF);
        @(posedge clk); #1;
        check("sat.hold", {16'd0, collide_cnt}, 32'h0000FFFF);
        $display("%0t sat: collide_cnt=%h", $time, collide_cnt);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
